dm_store_wb: RTL

Data memory for the pipelined MIPS core, with byte-enabled stores (sw/sh/sb) and the registered M→W load path. Inputs come from the M stage. On each clock edge the block performs the store, or captures the addressed word and its byte offset into W-stage registers. Those registers feed the W-stage byte/halfword extraction (`loadbyte`-style `data`/`addr` inputs).

---
 rtl/dm_store_wb.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/dm_store_wb.sv
// dm_store_wb: data memory for the pipelined MIPS core.
// Performs byte-enabled stores (sw/sh/sb) from the M stage and registers
// load results (word plus byte offset) into the W stage.
// Optional feature macro: DM_WRITE_LOG_EN (simulation write log of committed stores).
module dm_store_wb #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        we,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata_w,
  output logic [1:0]  addr_w,
  output logic        load_valid_w,
  output logic        misalign_w
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Store type encodings as presented by the M stage
  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_BAD = 2'b11
  } storeTypeT;

  logic [31:0] r_mem [0:DEPTH-1];
  logic [31:0] r_rdata;
  logic [1:0]  r_addr;
  logic        r_loadValid;
  logic        r_misalign;

  logic [DEPTH_LOG2-1:0] w_index;
  logic [3:0]            w_strobe;
  logic                  w_legal;
  logic [31:0]           w_wdataRep;
  logic [31:0]           w_oldWord;
  logic [31:0]           w_merged;
  logic                  w_doStore;
  logic                  w_reject;
  logic                  w_doLoad;
  storeTypeT             w_storeType;

  // Upper address bits beyond the array wrap away; the index is the low word bits
  assign w_index     = addr[DEPTH_LOG2+1:2];
  assign w_storeType = storeTypeT'(store_type);
  assign w_oldWord   = r_mem[w_index];

  // Decode store legality, byte strobe and lane-replicated write data
  always_comb begin
    w_strobe   = 4'b0000;
    w_legal    = 1'b0;
    w_wdataRep = wdata;
    case (w_storeType)
      ST_SW: begin
        w_legal    = (addr[1:0] == 2'b00);
        w_strobe   = 4'b1111;
        w_wdataRep = wdata;
      end
      ST_SH: begin
        w_legal    = ~addr[0];
        w_strobe   = addr[1] ? 4'b1100 : 4'b0011;
        w_wdataRep = {2{wdata[15:0]}};
      end
      ST_SB: begin
        w_legal    = 1'b1;
        w_strobe   = 4'b0001 << addr[1:0];
        w_wdataRep = {4{wdata[7:0]}};
      end
      default: begin
        w_legal    = 1'b0;
        w_strobe   = 4'b0000;
        w_wdataRep = wdata;
      end
    endcase
  end

  // Byte-wise merge of the replicated store data into the current word
  always_comb begin
    w_merged = w_oldWord;
    for (int b = 0; b < 4; b++) begin
      if (w_strobe[b]) begin
        w_merged[8*b +: 8] = w_wdataRep[8*b +: 8];
      end
    end
  end

  assign w_doStore = en & we & w_legal;
  assign w_reject  = en & we & ~w_legal;
  assign w_doLoad  = en & ~we;

  // Memory array: cleared by reset, written only by legal stores
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'h0;
      end
    end else if (w_doStore) begin
      r_mem[w_index] <= w_merged;
    end
  end

  // W-stage registers: capture loads, pulse flags, hold data otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata     <= 32'h0;
      r_addr      <= 2'b00;
      r_loadValid <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_loadValid <= w_doLoad;
      r_misalign  <= w_reject;
      if (w_doLoad) begin
        r_rdata <= w_oldWord;
        r_addr  <= addr[1:0];
      end
    end
  end

  assign rdata_w      = r_rdata;
  assign addr_w       = r_addr;
  assign load_valid_w = r_loadValid;
  assign misalign_w   = r_misalign;

`ifdef DM_WRITE_LOG_EN
  logic w_unused;
  assign w_unused = 1'b0;

  // Simulation log of every committed store with the resulting word
  always_ff @(posedge clk) begin
    if (!reset && w_doStore) begin
      $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, w_merged);
    end
  end
`else
  // pc and the address bits above the array are only consumed by the log
  logic w_unused;
  assign w_unused = ^{pc, addr[31:DEPTH_LOG2+2]};
`endif

endmodule
